// File: rtl/mor1kx_spr_master.sv
// SPR bus master: accepts one pipeline SPR request at a time, strobes the SPR bus
// until ack, abort or timeout, then returns a one-cycle completion pulse.
module mor1kx_spr_master #(
    parameter int unsigned OPTION_SPR_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        req_ready_o,
    input  logic        abort_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPTION_SPR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             done_ok;
    logic             done_to;

    // Next-state decode; abort beats ack, and ack beats timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (spr_bus_ack_i) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, bus-side and response registers; strobes are decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready_o  <= 1'b1;
            spr_access_o <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_err_o    <= 1'b0;
            spr_we_o     <= 1'b0;
            spr_addr_o   <= '0;
            spr_dat_o    <= '0;
        end else begin
            state        <= state_next;
            req_ready_o  <= (state_next == IDLE);
            spr_access_o <= (state_next == ACCESS);
            rsp_valid_o  <= (state_next == RESP);

            if (accept) begin
                cnt        <= '0;
                spr_we_o   <= req_we_i;
                spr_addr_o <= req_addr_i;
                spr_dat_o  <= req_dat_i;
            end else if (state == ACCESS) begin
                if (state_next != ACCESS) begin
                    spr_we_o  <= 1'b0;
                    spr_dat_o <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (done_ok) begin
                rsp_dat_o <= spr_we_o ? 32'h0 : spr_dat_i;
                rsp_err_o <= 1'b0;
            end else if (done_to) begin
                rsp_dat_o <= 32'h0;
                rsp_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mor1kx_spr_master.sv
// Bench for mor1kx_spr_master: directed scenarios with literal expectations, then
// random traffic, all compared each cycle against a transaction-level model.
module tb_mor1kx_spr_master;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_dat;
    logic        req_ready;
    logic        abort;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        spr_access;
    logic        spr_we;
    logic [15:0] spr_addr;
    logic [31:0] spr_wdat;
    logic        spr_ack;
    logic [31:0] rd_dat;
    logic        ack_rand;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mor1kx_spr_master #(.OPTION_SPR_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_dat_i    (req_dat),
        .req_ready_o  (req_ready),
        .abort_i      (abort),
        .rsp_valid_o  (rsp_valid),
        .rsp_dat_o    (rsp_dat),
        .rsp_err_o    (rsp_err),
        .spr_access_o (spr_access),
        .spr_we_o     (spr_we),
        .spr_addr_o   (spr_addr),
        .spr_dat_o    (spr_wdat),
        .spr_bus_ack_i(spr_ack),
        .spr_dat_i    (rd_dat)
    );

    // Responder acks combinationally whenever the strobe is up and ack_rand allows it.
    assign spr_ack = spr_access & ack_rand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: what the outputs must show after each clock edge.
    logic        m_ready, m_acc, m_we, m_rv, m_err;
    logic [15:0] m_addr;
    logic [31:0] m_wdat, m_rdat;
    int          m_cycles;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1; m_acc = 1'b0; m_we = 1'b0; m_addr = '0; m_wdat = '0;
            m_rv = 1'b0; m_rdat = '0; m_err = 1'b0; m_cycles = 0;
        end else if (m_rv) begin
            m_rv    = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            if (req_valid) begin
                m_ready  = 1'b0;
                m_acc    = 1'b1;
                m_we     = req_we;
                m_addr   = req_addr;
                m_wdat   = req_dat;
                m_cycles = 1;
            end
        end else if (m_acc) begin
            if (abort) begin
                m_acc = 1'b0; m_we = 1'b0; m_wdat = '0; m_ready = 1'b1;
            end else if (ack_rand) begin
                m_rdat = m_we ? 32'h0 : rd_dat;
                m_err  = 1'b0;
                m_acc = 1'b0; m_we = 1'b0; m_wdat = '0; m_rv = 1'b1;
            end else if (m_cycles == TMO) begin
                m_rdat = 32'h0;
                m_err  = 1'b1;
                m_acc = 1'b0; m_we = 1'b0; m_wdat = '0; m_rv = 1'b1;
            end else begin
                m_cycles++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  32'(req_ready),  32'(m_ready));
            chk("spr_access", 32'(spr_access), 32'(m_acc));
            chk("spr_we",     32'(spr_we),     32'(m_we));
            chk("spr_addr",   32'(spr_addr),   32'(m_addr));
            chk("spr_dat",    spr_wdat,        m_wdat);
            chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
            chk("rsp_dat",    rsp_dat,         m_rdat);
            chk("rsp_err",    32'(rsp_err),    32'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Present one request for a single cycle; returns in the first ACCESS cycle.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] dat);
        chk("issue_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_dat   = dat;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_dat = '0;
        abort = 1'b0; rd_dat = '0; ack_rand = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_outs", {rsp_dat[15:0], spr_addr}, 32'h0);

        // Read with combinational ack: strobe at cycle 1, response at cycle 2.
        ack_rand = 1'b1; rd_dat = 32'h0000_00F0;
        issue(1'b0, 16'h4800, 32'h0);
        chk("rd_access", 32'(spr_access), 32'h1);
        chk("rd_addr",   32'(spr_addr),   32'h4800);
        step();
        chk("rd_access_off", 32'(spr_access), 32'h0);
        chk("rd_valid", 32'(rsp_valid), 32'h1);
        chk("rd_dat",   rsp_dat,        32'h0000_00F0);
        chk("rd_err",   32'(rsp_err),   32'h0);
        step();
        chk("rd_ready_again", 32'(req_ready), 32'h1);

        // Write with ack in the 4th access cycle.
        ack_rand = 1'b0; rd_dat = 32'hDEAD_BEEF;
        issue(1'b1, 16'h4802, 32'h0000_0005);
        for (int k = 0; k < 4; k++) begin
            chk("wr_access", 32'(spr_access), 32'h1);
            chk("wr_we",     32'(spr_we),     32'h1);
            chk("wr_dat",    spr_wdat,        32'h5);
            if (k == 3) ack_rand = 1'b1;
            step();
        end
        ack_rand = 1'b0;
        chk("wr_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rdat",  rsp_dat,        32'h0);
        chk("wr_err",   32'(rsp_err),   32'h0);
        chk("wr_we_off", 32'(spr_we),   32'h0);
        step();

        // Timeout: strobe high for exactly TMO cycles, then error response.
        issue(1'b0, 16'h0011, 32'h0);
        n = 0;
        while (spr_access && n < 40) begin
            n++;
            step();
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk("tmo_valid",  32'(rsp_valid), 32'h1);
        chk("tmo_err",    32'(rsp_err),   32'h1);
        chk("tmo_dat",    rsp_dat,        32'h0);
        step();

        // Ack in the last access cycle wins over timeout.
        rd_dat = 32'h0000_ABCD;
        issue(1'b0, 16'h0022, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) ack_rand = 1'b1;
            step();
        end
        ack_rand = 1'b0;
        chk("bnd_valid", 32'(rsp_valid), 32'h1);
        chk("bnd_err",   32'(rsp_err),   32'h0);
        chk("bnd_dat",   rsp_dat,        32'h0000_ABCD);
        step();

        // Abort with ack in the 2nd access cycle: no response.
        issue(1'b1, 16'h0033, 32'h7777_0000);
        step();
        ack_rand = 1'b1; abort = 1'b1;
        step();
        ack_rand = 1'b0; abort = 1'b0;
        chk("abort_valid", 32'(rsp_valid),  32'h0);
        chk("abort_ready", 32'(req_ready),  32'h1);
        chk("abort_acc",   32'(spr_access), 32'h0);
        chk("abort_hold",  rsp_dat,         32'h0000_ABCD);
        step();

        // Reset in the middle of an access, then a normal read.
        issue(1'b1, 16'h0044, 32'h1234_5678);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_outs", {rsp_dat[7:0], 7'(spr_addr), spr_wdat[7:0], spr_access, spr_we,
                         rsp_valid, rsp_err, 4'h0}, 32'h0);
        chk("rst_rdat", rsp_dat, 32'h0);
        ack_rand = 1'b1; rd_dat = 32'h0000_1234;
        issue(1'b0, 16'h4801, 32'h0);
        step();
        chk("rst_rd_valid", 32'(rsp_valid), 32'h1);
        chk("rst_rd_dat",   rsp_dat,        32'h0000_1234);
        step();

        // Random traffic: high ack rate first, then sparse acks to exercise timeouts.
        for (int i = 0; i < 4000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_dat   = $urandom;
            rd_dat    = $urandom;
            ack_rand  = ($urandom_range(0, 99) < ((i < 2000) ? 40 : 3));
            abort     = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        req_valid = 1'b0; abort = 1'b0; ack_rand = 1'b0; rst = 1'b0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
